// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the parametrised system controller:
// FSM states, command opcodes and error codes.
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RF_W_ADDR,
    RF_W_DATA,
    RF_R_ADDR,
    RD_WAIT,
    OPER_A,
    OPER_B,
    ALU_FUNC,
    ALU_WAIT,
    TX_OUT
  } state_e;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  // States that only wait for a result, so an incoming byte is an overrun.
  function automatic logic isWaitState(input state_e s);
    return (s == RD_WAIT) || (s == ALU_WAIT) || (s == TX_OUT);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_ser.sv
// Result serializer: holds the result buffer and byte count and pushes
// bytes LSB first into the TX FIFO whenever it is not full.
module sys_ctrl_tx_ser #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ALU_OUT_W = 16,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [ALU_OUT_W-1:0] loadData_i,
  input  logic [CNT_W-1:0]     loadCnt_i,
  input  logic                 fifoFull_i,
  output logic [DATA_W-1:0]    txData_o,
  output logic                 txVld_o,
  output logic                 done_o
);

  logic [ALU_OUT_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 push;

  assign push = (cnt_q != '0) && !fifoFull_i;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (load_i) begin
      buf_d = loadData_i;
      cnt_d = loadCnt_i;
    end else if (push) begin
      buf_d = buf_q >> DATA_W;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // A push is held back while full, so the same byte stays at the head.
  assign txVld_o  = push && !rst_i;
  assign txData_o = buf_q[DATA_W-1:0];
  assign done_o   = push && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sys_ctrl_gen.sv
// System controller: decodes UART command frames into register-file and ALU
// operations, returns results via the TX FIFO and reports frame errors.
module sys_ctrl_gen
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FUN_W       = 4,
  parameter int unsigned ALU_OUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [DATA_W-1:0]    RDDATA,
  input  logic                 RDDATA_VLD,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  input  logic                 FIFO_FULL,
  output logic [FUN_W-1:0]     ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLK_EN,
  output logic [ADDR_W-1:0]    ADDRESS,
  output logic                 WR_EN,
  output logic                 RD_EN,
  output logic [DATA_W-1:0]    WR_DATA,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic                 CLK_DIV_EN,
  output logic                 BUSY,
  output logic                 ERR_VLD,
  output logic [1:0]           ERR_CODE
);

  localparam int unsigned NB    = ALU_OUT_W / DATA_W;
  localparam int unsigned CNT_W = $clog2(NB + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  if (ALU_OUT_W % DATA_W != 0) begin : gBadAluW
    $error("ALU_OUT_W must be a multiple of DATA_W");
  end
  if (ADDR_W > DATA_W) begin : gBadAddrW
    $error("ADDR_W must not exceed DATA_W");
  end
  if (FUN_W > DATA_W) begin : gBadFunW
    $error("FUN_W must not exceed DATA_W");
  end

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [TMO_W-1:0]     tmoCnt_q, tmoCnt_d;
  logic                 errVld_q;
  logic [1:0]           errCode_q;

  logic                 wrEn, rdEn, aluEn, clkEn;
  logic [ADDR_W-1:0]    address;
  logic [DATA_W-1:0]    wrData;
  logic [FUN_W-1:0]     aluFun;
  logic                 load;
  logic [ALU_OUT_W-1:0] loadData;
  logic [CNT_W-1:0]     loadCnt;
  logic                 errSet;
  logic [1:0]           errKind;
  logic                 txDone;
  logic                 countState;
  logic                 tmoHit;

  assign countState = (state_q != IDLE) && (state_q != TX_OUT);
  // A byte arriving on the expiry cycle keeps the frame alive.
  assign tmoHit = (TIMEOUT_CYC != 0) && countState && !RX_D_VLD &&
                  (tmoCnt_q == TMO_W'(TIMEOUT_CYC));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wrEn     = 1'b0;
    rdEn     = 1'b0;
    aluEn    = 1'b0;
    clkEn    = 1'b0;
    address  = '0;
    wrData   = '0;
    aluFun   = '1;
    load     = 1'b0;
    loadData = '0;
    loadCnt  = '0;
    errSet   = 1'b0;
    errKind  = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_W'(CMD_WR)) begin
            state_d = RF_W_ADDR;
          end else if (RX_P_DATA == DATA_W'(CMD_RD)) begin
            state_d = RF_R_ADDR;
          end else if (RX_P_DATA == DATA_W'(CMD_ALU_OP)) begin
            state_d = OPER_A;
          end else if (RX_P_DATA == DATA_W'(CMD_ALU_NOP)) begin
            state_d = ALU_FUNC;
          end else begin
            errSet  = 1'b1;
            errKind = ERR_BAD_CMD;
          end
        end
      end
      RF_W_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = RF_W_DATA;
        end
      end
      RF_W_DATA: begin
        if (RX_D_VLD) begin
          wrEn    = 1'b1;
          address = addr_q;
          wrData  = RX_P_DATA;
          state_d = IDLE;
        end
      end
      RF_R_ADDR: begin
        if (RX_D_VLD) begin
          rdEn    = 1'b1;
          address = RX_P_DATA[ADDR_W-1:0];
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RDDATA_VLD) begin
          load     = 1'b1;
          loadData = ALU_OUT_W'(RDDATA);
          loadCnt  = CNT_W'(1);
          state_d  = TX_OUT;
        end
      end
      OPER_A: begin
        if (RX_D_VLD) begin
          wrEn    = 1'b1;
          address = '0;
          wrData  = RX_P_DATA;
          state_d = OPER_B;
        end
      end
      OPER_B: begin
        if (RX_D_VLD) begin
          wrEn    = 1'b1;
          address = ADDR_W'(1);
          wrData  = RX_P_DATA;
          state_d = ALU_FUNC;
        end
      end
      ALU_FUNC: begin
        clkEn = 1'b1;
        if (RX_D_VLD) begin
          aluEn   = 1'b1;
          aluFun  = RX_P_DATA[FUN_W-1:0];
          state_d = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        clkEn = 1'b1;
        if (ALU_OUT_VLD) begin
          load     = 1'b1;
          loadData = ALU_OUT;
          loadCnt  = CNT_W'(NB);
          state_d  = TX_OUT;
        end
      end
      TX_OUT: begin
        if (txDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (RX_D_VLD && isWaitState(state_q)) begin
      errSet  = 1'b1;
      errKind = ERR_OVERRUN;
    end

    if (tmoHit) begin
      state_d = IDLE;
      load    = 1'b0;
      errSet  = 1'b1;
      errKind = ERR_TIMEOUT;
    end
  end

  always_comb begin
    tmoCnt_d = tmoCnt_q;
    if ((TIMEOUT_CYC == 0) || (state_d != state_q) || RX_D_VLD) begin
      tmoCnt_d = '0;
    end else if (countState) begin
      tmoCnt_d = tmoCnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tmoCnt_q  <= '0;
      errVld_q  <= 1'b0;
      errCode_q <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tmoCnt_q <= tmoCnt_d;
      errVld_q <= errSet;
      if (errSet) begin
        errCode_q <= errKind;
      end
    end
  end

  sys_ctrl_tx_ser #(
    .DATA_W    (DATA_W),
    .ALU_OUT_W (ALU_OUT_W),
    .CNT_W     (CNT_W)
  ) uTxSer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (load),
    .loadData_i (loadData),
    .loadCnt_i  (loadCnt),
    .fifoFull_i (FIFO_FULL),
    .txData_o   (TX_P_DATA),
    .txVld_o    (TX_D_VLD),
    .done_o     (txDone)
  );

  assign WR_EN      = wrEn && !RST;
  assign RD_EN      = rdEn && !RST;
  assign ALU_EN     = aluEn && !RST;
  assign CLK_EN     = clkEn;
  assign ADDRESS    = address;
  assign WR_DATA    = wrData;
  assign ALU_FUN    = aluFun;
  assign CLK_DIV_EN = 1'b1;
  assign BUSY       = (state_q != IDLE);
  assign ERR_VLD    = errVld_q;
  assign ERR_CODE   = errCode_q;

endmodule
